// File: rtl/sync_down_counter_jk_pkg.sv
// rtl/sync_down_counter_jk_pkg.sv - shared constants for the JK down counter
package sync_down_counter_jk_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

  // Sized to the widest legal counter; users slice off the low WIDTH bits.
  localparam logic [WIDTH_MAX-1:0] COUNT_RST  = '0;
  localparam logic [WIDTH_MAX-1:0] RELOAD_RST = '1;

endpackage

// File: rtl/jk_ff_sync.sv
// rtl/jk_ff_sync.sv - JK flip-flop with synchronous active-high reset
module jk_ff_sync (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign qb = ~q;

endmodule

// File: rtl/sync_down_counter_jk.sv
// rtl/sync_down_counter_jk.sv - synchronous JK down counter with load, auto-reload and tc pulse
module sync_down_counter_jk
  import sync_down_counter_jk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("sync_down_counter_jk: WIDTH out of range");
  end

  logic [WIDTH-1:0] qb_bits;
  logic [WIDTH-1:0] borrow;
  logic [WIDTH-1:0] j_bits;
  logic [WIDTH-1:0] k_bits;
  logic [WIDTH-1:0] reload;
  logic             acc;

  assign zero = &qb_bits;

  // borrow[i]: every lower bit is zero, so bit i toggles on a decrement.
  always_comb begin
    borrow = '0;
    acc    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      borrow[i] = acc;
      acc       = acc & qb_bits[i];
    end
  end

  // Plain underflow needs no special case: all borrows are set, so 0 toggles to all ones.
  always_comb begin
    j_bits = '0;
    k_bits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (load) begin
        j_bits[i] = load_val[i];
        k_bits[i] = ~load_val[i];
      end else if (en && zero && auto_reload) begin
        j_bits[i] = reload[i];
        k_bits[i] = ~reload[i];
      end else if (en && borrow[i]) begin
        j_bits[i] = 1'b1;
        k_bits[i] = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff_sync u_ff (
      .clk (clk),
      .rst (rst),
      .j   (j_bits[i]),
      .k   (k_bits[i]),
      .q   (count[i]),
      .qb  (qb_bits[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reload <= RELOAD_RST[WIDTH-1:0];
      tc     <= 1'b0;
    end else begin
      if (load) begin
        reload <= load_val;
      end
      tc <= ~load & en & zero;
    end
  end

endmodule

// File: tb/tb_sync_down_counter_jk.sv
// tb/tb_sync_down_counter_jk.sv - randomized and directed checks against a behavioural model
module tb_sync_down_counter_jk;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] count;
  logic         zero;
  logic         tc;

  int checks = 0;
  int errors = 0;

  int m_count  = 0;
  int m_reload = MAXV;
  int m_tc     = 0;
  int tc_seen  = 0;

  sync_down_counter_jk #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load        (load),
    .load_val    (load_val),
    .auto_reload (auto_reload),
    .count       (count),
    .zero        (zero),
    .tc          (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One clock: drive controls, advance the model by the behavioural rules, compare.
  task automatic step(input logic r, input logic ld, input int lv, input logic e,
                      input logic ar, input string tag);
    @(negedge clk);
    rst = r; load = ld; load_val = W'(lv); en = e; auto_reload = ar;
    @(posedge clk);
    if (r) begin
      m_count = 0; m_reload = MAXV; m_tc = 0;
    end else if (ld) begin
      m_count = lv; m_reload = lv; m_tc = 0;
    end else if (e) begin
      if (m_count == 0) begin
        m_count = ar ? m_reload : MAXV;
        m_tc = 1;
      end else begin
        m_count = m_count - 1;
        m_tc = 0;
      end
    end else begin
      m_tc = 0;
    end
    #1;
    check({tag, "_count"}, int'(count), m_count);
    check({tag, "_zero"}, int'(zero), (m_count == 0) ? 1 : 0);
    check({tag, "_tc"}, int'(tc), m_tc);
  endtask

  initial begin
    // reset then count: 0 -> F -> E -> D
    step(1, 0, 0, 0, 0, "rst0");
    step(1, 0, 0, 0, 0, "rst1");
    check("reset_count_const", int'(count), 0);
    step(0, 0, 0, 1, 0, "dec_f");
    check("wrap_to_f", int'(count), 15);
    check("wrap_tc", int'(tc), 1);
    step(0, 0, 0, 1, 0, "dec_e");
    step(0, 0, 0, 1, 0, "dec_d");
    check("dec_d_const", int'(count), 13);

    // load beats enable
    step(0, 1, 9, 0, 0, "load9");
    step(0, 1, 5, 1, 0, "load_pri");
    check("load_pri_const", int'(count), 5);

    // auto-reload divide-by-4
    step(0, 1, 3, 0, 1, "load3");
    tc_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 1, 1, "div4");
      tc_seen += int'(tc);
    end
    check("div4_tc_count", tc_seen, 3);

    // enable gating
    step(0, 1, 7, 0, 0, "load7");
    step(0, 0, 0, 1, 0, "gate1");
    step(0, 0, 0, 0, 0, "gate2");
    step(0, 0, 0, 0, 0, "gate3");
    step(0, 0, 0, 1, 0, "gate4");
    check("gate_const", int'(count), 5);

    // reset on an underflow edge, then reload must be all ones
    step(0, 1, 0, 0, 1, "load0");
    step(1, 0, 0, 1, 1, "rst_uf");
    check("rst_uf_tc", int'(tc), 0);
    step(0, 0, 0, 1, 1, "reload_f");
    check("reload_f_const", int'(count), 15);

    // zero reload: count pinned at 0, tc continuously high
    step(0, 1, 0, 0, 1, "zload");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, "zrel");
    check("zrel_tc_const", int'(tc), 1);

    // randomized traffic; auto_reload toggles freely outside underflow too
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, MAXV)), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
